// File: rtl/agc_pkg.sv
// Shared definitions for the IQ automatic gain control block.
// Holds the loop state encoding, datapath widths, default loop constants and
// the scale-and-saturate helper used by the stage-2 multiplier.
package agc_pkg;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_HOLD    = 2'd2
  } agc_state_t;

  localparam int IN_W   = 16;  // sfix16_En15 input samples
  localparam int OUT_W  = 39;  // sfix39_En36 output samples
  localparam int MAG_W  = 17;  // ufix17_En13 magnitude
  localparam int GAIN_W = 16;  // ufix16_En8 gain

  localparam int DEF_BLK_LOG2    = 6;
  localparam int DEF_REF_LEVEL   = 8192;
  localparam int DEF_DEADBAND    = 256;
  localparam int DEF_LOCK_BLOCKS = 4;
  localparam int DEF_GAIN_INIT   = 256;
  localparam int DEF_GAIN_MIN    = 16;
  localparam int DEF_GAIN_MAX    = 65535;

  localparam int STEP_SH_ACQ = 3;  // coarse step: gain/8
  localparam int STEP_SH_TRK = 6;  // fine step: gain/64

  // x (En15) * g (En8) gives En23; shifting by 13 lands on En36.
  // Returns {saturated, value}. The shifted product is saturated when its
  // bits above the sfix39 sign position are not all copies of the sign.
  function automatic logic [OUT_W:0] scale_sat(input logic signed [IN_W-1:0]   x,
                                               input logic        [GAIN_W-1:0] g);
    logic signed [32:0] prod;
    logic signed [45:0] shifted;
    prod    = 33'(x) * 33'($signed({1'b0, g}));
    shifted = {prod, 13'b0};
    if ((&shifted[45:38]) || (~|shifted[45:38]))
      return {1'b0, shifted[OUT_W-1:0]};
    else if (shifted[45])
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/agc_mag_est.sv
// Combinational I/Q magnitude estimate: max(|I|,|Q|) + min(|I|,|Q|)/2.
// Ports:
//   x_i, x_q : signed sfix16_En13 components
//   mag      : ufix17_En13 estimate
module agc_mag_est
  import agc_pkg::*;
(
  input  logic signed [IN_W-1:0]  x_i,
  input  logic signed [IN_W-1:0]  x_q,
  output logic        [MAG_W-1:0] mag
);

  logic [IN_W-1:0] abs_i, abs_q, mx, mn;

  // The most negative code has no positive twin; it clips to full scale.
  function automatic logic [IN_W-1:0] abs_clip(input logic signed [IN_W-1:0] x);
    if (x == {1'b1, {(IN_W-1){1'b0}}})
      return {1'b0, {(IN_W-1){1'b1}}};
    else if (x[IN_W-1])
      return IN_W'(-x);
    else
      return x;
  endfunction

  assign abs_i = abs_clip(x_i);
  assign abs_q = abs_clip(x_q);
  assign mx    = (abs_i > abs_q) ? abs_i : abs_q;
  assign mn    = (abs_i > abs_q) ? abs_q : abs_i;
  assign mag   = MAG_W'(mx) + MAG_W'(mn >> 1);

endmodule

// File: rtl/agc_iq.sv
// Block-based AGC for complex baseband ahead of the FM demodulator.
// Two-stage pipeline (input register, gain multiply + saturation); the loop
// averages the output magnitude over 2^BLK_LOG2 samples and nudges the gain
// once per block.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   clk_enable        : sample strobe, all loop/datapath state advances on it
//   in_I, in_Q        : sfix16_En15 input samples
//   agc_hold          : freeze the gain loop
//   out_I, out_Q      : sfix39_En36 scaled samples
//   ce_out            : clk_enable delayed by two clocks
//   gain              : current gain, ufix16_En8
//   locked            : loop is in TRACK
//   sat               : current output sample clipped on I or Q
//
// state    | meaning
// ACQUIRE  | coarse steps, counting consecutive in-band blocks
// TRACK    | locked, fine steps, falls back on a large level error
// HOLD     | gain, accumulator and block counter frozen
module agc_iq
  import agc_pkg::*;
#(
  parameter int BLK_LOG2    = DEF_BLK_LOG2,
  parameter int REF_LEVEL   = DEF_REF_LEVEL,
  parameter int DEADBAND    = DEF_DEADBAND,
  parameter int LOCK_BLOCKS = DEF_LOCK_BLOCKS,
  parameter int GAIN_INIT   = DEF_GAIN_INIT,
  parameter int GAIN_MIN    = DEF_GAIN_MIN,
  parameter int GAIN_MAX    = DEF_GAIN_MAX
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic signed [IN_W-1:0]   in_I,
  input  logic signed [IN_W-1:0]   in_Q,
  input  logic                     agc_hold,
  output logic signed [OUT_W-1:0]  out_I,
  output logic signed [OUT_W-1:0]  out_Q,
  output logic                     ce_out,
  output logic        [GAIN_W-1:0] gain,
  output logic                     locked,
  output logic                     sat
);

  localparam int ACC_W = MAG_W + BLK_LOG2;
  localparam int CNT_W = BLK_LOG2 + 1;
  localparam int LCK_W = $clog2(LOCK_BLOCKS + 1);

  agc_state_t          state, state_nxt;
  logic signed [IN_W-1:0] d1_i, d1_q;
  logic                ce_d1;
  logic [OUT_W:0]      sr_i, sr_q;
  logic [MAG_W-1:0]    mag, avg;
  logic [ACC_W-1:0]    acc, acc_nxt;
  logic [CNT_W-1:0]    blk_cnt, cnt_nxt;
  logic [LCK_W-1:0]    lock_cnt, lock_nxt;
  logic [GAIN_W-1:0]   gain_nxt, step_raw, step, gain_up, gain_dn;
  logic [GAIN_W:0]     sum_up, dif_dn;
  logic                blk_end, above, below, far;
  int                  err;

  // ---------------- datapath ----------------
  assign sr_i = scale_sat(d1_i, gain);
  assign sr_q = scale_sat(d1_q, gain);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1_i   <= '0;
      d1_q   <= '0;
      out_I  <= '0;
      out_Q  <= '0;
      sat    <= 1'b0;
      ce_d1  <= 1'b0;
      ce_out <= 1'b0;
    end else begin
      ce_d1  <= clk_enable;
      ce_out <= ce_d1;
      if (clk_enable) begin
        d1_i  <= in_I;
        d1_q  <= in_Q;
        out_I <= sr_i[OUT_W-1:0];
        out_Q <= sr_q[OUT_W-1:0];
        sat   <= sr_i[OUT_W] | sr_q[OUT_W];
      end
    end
  end

  agc_mag_est u_mag (
    .x_i (out_I[OUT_W-1:OUT_W-IN_W]),
    .x_q (out_Q[OUT_W-1:OUT_W-IN_W]),
    .mag (mag)
  );

  // ---------------- level detector / gain step ----------------
  // The block ends on the sample after the 2^BLK_LOG2-th one; that sample
  // seeds the next block.
  assign blk_end = (blk_cnt == CNT_W'(2 ** BLK_LOG2));
  assign avg     = MAG_W'(acc >> BLK_LOG2);
  assign err     = int'(avg) - REF_LEVEL;
  assign above   = err > DEADBAND;
  assign below   = err < -DEADBAND;
  assign far     = (err > 4 * DEADBAND) || (err < -4 * DEADBAND);

  assign step_raw = (state == ST_TRACK) ? (gain >> STEP_SH_TRK) : (gain >> STEP_SH_ACQ);
  assign step     = (step_raw == '0) ? GAIN_W'(1) : step_raw;
  assign sum_up   = {1'b0, gain} + {1'b0, step};
  assign dif_dn   = {1'b0, gain} - {1'b0, step};
  assign gain_up  = (int'(sum_up) > GAIN_MAX) ? GAIN_W'(GAIN_MAX) : sum_up[GAIN_W-1:0];
  assign gain_dn  = (dif_dn[GAIN_W] || int'(dif_dn) < GAIN_MIN) ?
                    GAIN_W'(GAIN_MIN) : dif_dn[GAIN_W-1:0];

  // ---------------- loop FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_ACQUIRE;
    else if (clk_enable) state <= state_nxt;
  end

  // Step size follows the state the block was measured in, so the block that
  // drops TRACK still uses the fine step.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = blk_cnt;
    lock_nxt  = lock_cnt;
    gain_nxt  = gain;
    unique case (state)
      ST_HOLD: begin
        if (!agc_hold) begin
          state_nxt = ST_ACQUIRE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          lock_nxt  = '0;
        end
      end
      default: begin
        if (agc_hold) begin
          state_nxt = ST_HOLD;
        end else if (blk_end) begin
          acc_nxt = ACC_W'(mag);
          cnt_nxt = CNT_W'(1);
          if (above)      gain_nxt = gain_dn;
          else if (below) gain_nxt = gain_up;
          if (state == ST_ACQUIRE) begin
            if (above || below) begin
              lock_nxt = '0;
            end else if (lock_cnt == LCK_W'(LOCK_BLOCKS - 1)) begin
              state_nxt = ST_TRACK;
              lock_nxt  = '0;
            end else begin
              lock_nxt = lock_cnt + 1'b1;
            end
          end else if (far) begin
            state_nxt = ST_ACQUIRE;
            lock_nxt  = '0;
          end
        end else begin
          acc_nxt = acc + ACC_W'(mag);
          cnt_nxt = blk_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      blk_cnt  <= '0;
      lock_cnt <= '0;
      gain     <= GAIN_W'(GAIN_INIT);
    end else if (clk_enable) begin
      acc      <= acc_nxt;
      blk_cnt  <= cnt_nxt;
      lock_cnt <= lock_nxt;
      gain     <= gain_nxt;
    end
  end

  assign locked = (state == ST_TRACK);

endmodule
